// File: rtl/sprite_pkg.sv
// sprite_pkg: keycodes, coordinate/velocity types and sweep FSM states
// shared by the sprite motion engine.
package sprite_pkg;

    localparam int DEF_COORD_W = 10;

    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;
    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_S = 8'h16;

    typedef logic [DEF_COORD_W-1:0] coord_t;
    typedef logic signed [DEF_COORD_W:0] vel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/sprite_motion_engine_step.sv
// sprite_step: combinational next position/velocity of one sprite
// (keycode steering, wall bounce, move, clamp).
module sprite_step
    import sprite_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int X_MAX   = 639,
    parameter int Y_MAX   = 479,
    parameter int SIZE    = 4,
    parameter int STEP    = 1
) (
    input  logic                      obj0_i,
    input  logic [7:0]                keycode_i,
    input  logic [COORD_W-1:0]        x_i,
    input  logic [COORD_W-1:0]        y_i,
    input  logic signed [COORD_W:0]   vx_i,
    input  logic signed [COORD_W:0]   vy_i,
    output logic [COORD_W-1:0]        x_o,
    output logic [COORD_W-1:0]        y_o,
    output logic signed [COORD_W:0]   vx_o,
    output logic signed [COORD_W:0]   vy_o
);

    localparam int W = COORD_W + 2;
    localparam logic signed [COORD_W:0] VP = (COORD_W+1)'(STEP);
    localparam logic signed [COORD_W:0] VN = -VP;

    logic signed [COORD_W:0] kvx, kvy;

    // Walls take priority over steering, even for a stationary sprite.
    function automatic logic signed [COORD_W:0] bounce(
        input logic [COORD_W-1:0]      p,
        input logic signed [COORD_W:0] v,
        input int                      mx
    );
        logic [W-1:0] pe;
        pe = {2'b00, p};
        if (pe + W'(SIZE) >= W'(mx)) return VN;
        if (pe <= W'(SIZE)) return VP;
        return v;
    endfunction

    function automatic logic [COORD_W-1:0] move(
        input logic [COORD_W-1:0]      p,
        input logic signed [COORD_W:0] v,
        input int                      mx
    );
        logic signed [W-1:0] s;
        s = $signed({2'b00, p}) + $signed({v[COORD_W], v});
        if (s < $signed(W'(SIZE))) return COORD_W'(SIZE);
        if (s > $signed(W'(mx - SIZE))) return COORD_W'(mx - SIZE);
        return s[COORD_W-1:0];
    endfunction

    always_comb begin
        kvx = vx_i;
        kvy = vy_i;
        if (obj0_i) begin
            unique case (keycode_i)
                KEY_A:   begin kvx = VN; kvy = '0; end
                KEY_D:   begin kvx = VP; kvy = '0; end
                KEY_W:   begin kvx = '0; kvy = VN; end
                KEY_S:   begin kvx = '0; kvy = VP; end
                default: ;
            endcase
        end
    end

    assign vx_o = bounce(x_i, kvx, X_MAX);
    assign vy_o = bounce(y_i, kvy, Y_MAX);
    assign x_o  = move(x_i, vx_o, X_MAX);
    assign y_o  = move(y_i, vy_o, Y_MAX);

endmodule

// File: rtl/sprite_motion_engine.sv
// sprite_motion_engine: per-frame sweep updating N_OBJ sprites, plus a
// registered per-pixel hit with lowest-index priority.
module sprite_motion_engine
    import sprite_pkg::*;
#(
    parameter int N_OBJ   = 4,
    parameter int COORD_W = 10,
    parameter int X_MAX   = 639,
    parameter int Y_MAX   = 479,
    parameter int SIZE    = 4,
    parameter int STEP    = 1,
    localparam int IDW    = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     frame_clk,
    input  logic [7:0]               keycode,
    input  logic [COORD_W-1:0]       DrawX,
    input  logic [COORD_W-1:0]       DrawY,
    output logic [N_OBJ*COORD_W-1:0] obj_x,
    output logic [N_OBJ*COORD_W-1:0] obj_y,
    output logic                     hit,
    output logic [IDW-1:0]           hit_id,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     overrun
);

    localparam logic signed [COORD_W:0] VP = (COORD_W+1)'(STEP);
    localparam logic signed [COORD_W:0] VN = -VP;
    localparam logic [COORD_W-1:0]      Y0 = COORD_W'((Y_MAX + 1) / 2);
    localparam int                      XSP = (X_MAX + 1) / (N_OBJ + 1);

    // fs_q: [0] sync stage 1, [1] sync stage 2, [2] previous for edge detect
    logic [2:0]              fs_q;
    logic                    tick;
    state_t                  state_q, state_d;
    logic [IDW-1:0]          idx_q, idx_d;
    logic                    ovr_q, ovr_d;
    logic [COORD_W-1:0]      x_q [N_OBJ];
    logic [COORD_W-1:0]      y_q [N_OBJ];
    logic signed [COORD_W:0] vx_q [N_OBJ];
    logic signed [COORD_W:0] vy_q [N_OBJ];
    logic [COORD_W-1:0]      nx, ny;
    logic signed [COORD_W:0] nvx, nvy;
    logic                    hit_q, hit_d;
    logic [IDW-1:0]          hid_q, hid_d;

    assign tick = fs_q[1] & ~fs_q[2];

    function automatic logic in_box(
        input logic [COORD_W-1:0] a,
        input logic [COORD_W-1:0] b
    );
        logic [COORD_W-1:0] d;
        d = (a >= b) ? a - b : b - a;
        return d <= COORD_W'(SIZE);
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ovr_d   = ovr_q;
        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = UPDATE;
                    idx_d   = '0;
                end
            end
            UPDATE: begin
                if (tick) ovr_d = 1'b1;
                if (idx_q == IDW'(N_OBJ - 1)) state_d = DONE;
                else idx_d = idx_q + 1'b1;
            end
            DONE: begin
                if (tick) ovr_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    sprite_step #(
        .COORD_W (COORD_W),
        .X_MAX   (X_MAX),
        .Y_MAX   (Y_MAX),
        .SIZE    (SIZE),
        .STEP    (STEP)
    ) u_step (
        .obj0_i    (idx_q == '0),
        .keycode_i (keycode),
        .x_i       (x_q[idx_q]),
        .y_i       (y_q[idx_q]),
        .vx_i      (vx_q[idx_q]),
        .vy_i      (vy_q[idx_q]),
        .x_o       (nx),
        .y_o       (ny),
        .vx_o      (nvx),
        .vy_o      (nvy)
    );

    always_comb begin
        hit_d = 1'b0;
        hid_d = '0;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (in_box(DrawX, x_q[i]) && in_box(DrawY, y_q[i])) begin
                hit_d = 1'b1;
                hid_d = IDW'(i);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fs_q    <= '0;
            state_q <= IDLE;
            idx_q   <= '0;
            ovr_q   <= 1'b0;
            hit_q   <= 1'b0;
            hid_q   <= '0;
        end else begin
            fs_q    <= {fs_q[1], fs_q[0], frame_clk};
            state_q <= state_d;
            idx_q   <= idx_d;
            ovr_q   <= ovr_d;
            hit_q   <= hit_d;
            hid_q   <= hid_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < N_OBJ; i++) begin
                x_q[i]  <= COORD_W'(XSP * (i + 1));
                y_q[i]  <= Y0;
                vx_q[i] <= (i == 0) ? '0 : ((i % 2 == 1) ? VP : VN);
                vy_q[i] <= (i == 0) ? '0 : VP;
            end
        end else if (state_q == UPDATE) begin
            x_q[idx_q]  <= nx;
            y_q[idx_q]  <= ny;
            vx_q[idx_q] <= nvx;
            vy_q[idx_q] <= nvy;
        end
    end

    for (genvar i = 0; i < N_OBJ; i++) begin : g_pack
        assign obj_x[i*COORD_W +: COORD_W] = x_q[i];
        assign obj_y[i*COORD_W +: COORD_W] = y_q[i];
    end

    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);
    assign overrun    = ovr_q;
    assign hit        = hit_q;
    assign hit_id     = hid_q;

endmodule

// File: tb/tb_sprite_motion_engine.sv
// tb_sprite_motion_engine: random frames and pixel probes against an
// integer reference model; frame results checked through a scoreboard.
module tb_sprite_motion_engine;

    localparam int N  = 4;
    localparam int CW = 10;
    localparam int SZ = 4;
    localparam int XM = 639;
    localparam int YM = 479;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_clk = 1'b0;
    logic [7:0]    keycode = 8'h00;
    logic [CW-1:0] draw_x = '0;
    logic [CW-1:0] draw_y = '0;
    logic [N*CW-1:0] obj_x, obj_y;
    logic          hit;
    logic [1:0]    hit_id;
    logic          busy, frame_done, overrun;

    int errors = 0;
    int checks = 0;
    int frames_seen = 0;

    int mx[N], my[N], mvx[N], mvy[N];

    typedef struct {
        int x[N];
        int y[N];
    } snap_t;
    snap_t exp_q[$];

    sprite_motion_engine dut (
        .Clk        (clk),
        .Reset_n    (rst_n),
        .frame_clk  (frame_clk),
        .keycode    (keycode),
        .DrawX      (draw_x),
        .DrawY      (draw_y),
        .obj_x      (obj_x),
        .obj_y      (obj_y),
        .hit        (hit),
        .hit_id     (hit_id),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int dut_x(input int i);
        return int'(obj_x[i*CW +: CW]);
    endfunction

    function automatic int dut_y(input int i);
        return int'(obj_y[i*CW +: CW]);
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i]  = ((XM + 1) / (N + 1)) * (i + 1);
            my[i]  = (YM + 1) / 2;
            mvx[i] = (i == 0) ? 0 : ((i % 2 == 1) ? 1 : -1);
            mvy[i] = (i == 0) ? 0 : 1;
        end
    endtask

    task automatic model_frame(input logic [7:0] kc);
        int vx;
        int vy;
        for (int i = 0; i < N; i++) begin
            vx = mvx[i];
            vy = mvy[i];
            if (i == 0) begin
                case (kc)
                    8'h04: begin vx = -1; vy = 0; end
                    8'h07: begin vx = 1;  vy = 0; end
                    8'h1A: begin vx = 0;  vy = -1; end
                    8'h16: begin vx = 0;  vy = 1; end
                    default: ;
                endcase
            end
            if (mx[i] + SZ >= XM) vx = -1;
            else if (mx[i] <= SZ) vx = 1;
            if (my[i] + SZ >= YM) vy = -1;
            else if (my[i] <= SZ) vy = 1;
            mvx[i] = vx;
            mvy[i] = vy;
            mx[i] = clampi(mx[i] + vx, SZ, XM - SZ);
            my[i] = clampi(my[i] + vy, SZ, YM - SZ);
        end
    endtask

    task automatic push_snap();
        snap_t s;
        for (int i = 0; i < N; i++) begin
            s.x[i] = mx[i];
            s.y[i] = my[i];
        end
        exp_q.push_back(s);
    endtask

    task automatic model_hit(input int dx, input int dy,
                             output int h, output int id);
        h = 0;
        id = 0;
        for (int i = 0; i < N; i++) begin
            if (h == 0) begin
                if ((dx - mx[i] <= SZ) && (mx[i] - dx <= SZ) &&
                    (dy - my[i] <= SZ) && (my[i] - dy <= SZ)) begin
                    h = 1;
                    id = i;
                end
            end
        end
    endtask

    task automatic probe(input int dx, input int dy);
        int h;
        int id;
        model_hit(dx, dy, h, id);
        draw_x = CW'(dx);
        draw_y = CW'(dy);
        @(posedge clk);
        #1;
        chk($sformatf("hit(%0d,%0d)", dx, dy), int'(hit), h);
        chk($sformatf("hit_id(%0d,%0d)", dx, dy), int'(hit_id), id);
    endtask

    task automatic run_frame(input logic [7:0] kc, input bit chk_lat);
        int n;
        keycode = kc;
        model_frame(kc);
        push_snap();
        @(posedge clk);
        #1;
        frame_clk = 1'b1;
        n = 0;
        while (frame_done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("frame_done_seen", int'(frame_done === 1'b1), 1);
        if (chk_lat) chk("sweep_latency_edges", n, 7);
        frame_clk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        frame_clk = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rand_key();
        case ($urandom_range(0, 4))
            0: return 8'h04;
            1: return 8'h07;
            2: return 8'h1A;
            3: return 8'h16;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // Scoreboard monitor: every frame_done pops one expected snapshot.
    initial begin
        snap_t e;
        forever begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                frames_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame_done: got frame %0d expected none",
                             frames_seen);
                end else begin
                    e = exp_q.pop_front();
                    for (int i = 0; i < N; i++) begin
                        chk($sformatf("obj%0d_x", i), dut_x(i), e.x[i]);
                        chk($sformatf("obj%0d_y", i), dut_y(i), e.y[i]);
                    end
                end
            end
        end
    end

    initial begin
        int nf;
        int j;
        int dx;
        int dy;

        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rst_obj%0d_x", i), dut_x(i), mx[i]);
            chk($sformatf("rst_obj%0d_y", i), dut_y(i), my[i]);
        end
        chk("rst_obj0_x_const", dut_x(0), 128);
        chk("rst_obj2_x_const", dut_x(2), 384);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_hit", int'(hit), 0);
        chk("rst_hit_id", int'(hit_id), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        probe(128, 244);
        probe(128, 245);
        probe(124, 236);
        probe(123, 240);

        run_frame(8'h07, 1'b1);
        chk("f1_obj0_x", dut_x(0), 129);
        chk("f1_obj0_y", dut_y(0), 240);
        chk("f1_obj1_x", dut_x(1), 257);
        chk("f1_obj1_y", dut_y(1), 241);
        chk("f1_obj2_x", dut_x(2), 383);
        chk("f1_obj2_y", dut_y(2), 241);

        repeat (236) run_frame(8'h1A, 1'b0);
        chk("w_top_y", dut_y(0), 4);
        run_frame(8'h1A, 1'b0);
        chk("w_bounce_y", dut_y(0), 5);
        repeat (9) run_frame(8'h1A, 1'b0);
        chk("w_floor_y", int'(dut_y(0) >= SZ), 1);

        repeat (25) run_frame(rand_key(), 1'b0);
        repeat (40) begin
            j = int'($urandom_range(0, N - 1));
            dx = mx[j] + int'($urandom_range(0, 14)) - 7;
            dy = my[j] + int'($urandom_range(0, 14)) - 7;
            if (dx < 0) dx = 0;
            if (dy < 0) dy = 0;
            probe(dx, dy);
        end

        apply_reset();
        repeat (62) run_frame(8'h00, 1'b0);
        probe(320, my[1]);
        chk("overlap_lowest_id", int'(hit_id), 1);
        probe(mx[2] + 4, my[2]);

        nf = frames_seen;
        keycode = 8'h16;
        model_frame(8'h16);
        push_snap();
        @(posedge clk);
        #1;
        frame_clk = 1'b1;
        j = 0;
        while (busy !== 1'b1 && j < 20) begin
            @(posedge clk);
            #1;
            j++;
        end
        chk("ovr_busy_seen", int'(busy === 1'b1), 1);
        frame_clk = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        frame_clk = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("overrun_set", int'(overrun), 1);
        chk("ovr_busy_idle", int'(busy), 0);
        chk("ovr_one_sweep", frames_seen, nf + 1);
        frame_clk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("overrun_sticky", int'(overrun), 1);

        keycode = 8'h07;
        @(posedge clk);
        #1;
        frame_clk = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        frame_clk = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("midrst_obj%0d_x", i), dut_x(i), mx[i]);
            chk($sformatf("midrst_obj%0d_y", i), dut_y(i), my[i]);
        end
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_overrun", int'(overrun), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_sweep", int'(busy), 0);

        run_frame(8'h04, 1'b1);
        run_frame(8'h16, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
